frog_move_encoder: RTL and testbench
====================================

Name: frog_move_encoder

Overview:
- Converts the four raw player push-buttons into clean, single-cycle, mutually exclusive move pulses L/U/D/R.
- These pulses drive the inputs of every frog LED cell in the array.
- The block is the producer end of the frog cell's move interface: a cell acts only on exactly-one-hot move inputs, and this block guarantees that form.
- It sits between the board KEY pins and the frog cell grid, one instance per player.

Parameters:
- DEBOUNCE_CYCLES, 16, number of consecutive stable synchronized samples required to accept a key level change (>=1).
- HOLD_REPEAT, 0, 1 enables auto-repeat while a single key stays held; 0 gives one pulse per press.
- REPEAT_CYCLES, 32, period in clk cycles between repeat pulses when HOLD_REPEAT=1 (>=2).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous active-low reset (0 = reset asserted)
- resetRound  input  1  synchronous round restart, active-high
- keyRaw  input  4  raw asynchronous buttons, active-low, bit order {3:L, 2:U, 1:D, 0:R}
- L  output  1  move-left pulse, one cycle
- U  output  1  move-up pulse, one cycle
- D  output  1  move-down pulse, one cycle
- R  output  1  move-right pulse, one cycle
- conflict  output  1  one-cycle pulse when a multi-key press is rejected

Behaviour:
- One clock domain. reset is asynchronous and active-low.
- While reset=0:
  - synchronizer flops = 1 (released)
  - accepted key state held[3:0] = 0
  - debounce counters = 0
  - FSM = IDLE
  - L=U=D=R=conflict=0
- All outputs are registered.
- Per key:
  - 2-flop synchronizer on keyRaw.
  - Counter increments each cycle the synchronized level differs from the accepted level, and clears to 0 on any cycle it matches.
  - When the counter is at DEBOUNCE_CYCLES-1 and the mismatch is still present, the accepted level flips and the counter clears.
  - held[i] = accepted level is pressed (pin low).
- Latency: a move pulse is high in the cycle following clock edge DEBOUNCE_CYCLES+3, counting the first edge that samples the new raw level as edge 1.
- FSM states: IDLE, HOLD, BLOCK, plus an internal latched direction dir[1:0].
  - IDLE, held==0: stay.
  - IDLE, held one-hot: latch dir, pulse that output next cycle, go HOLD, clear repeat counter.
  - IDLE, held has >=2 bits: go BLOCK, pulse conflict, no move.
  - HOLD, held==0: go IDLE.
  - HOLD, held != one-hot of dir (extra key added, or key swapped without a cycle of held==0): go BLOCK, pulse conflict.
  - HOLD, HOLD_REPEAT=1: repeat counter increments each HOLD cycle. At REPEAT_CYCLES-1 it wraps to 0 and pulses dir again, so pulses are spaced exactly REPEAT_CYCLES cycles apart.
  - BLOCK: no outputs; go IDLE only when held==0.
- resetRound=1 (synchronous):
  - FSM -> BLOCK; move outputs and conflict = 0 next cycle.
  - Debounce state is kept, so a key still held at round start never moves the frog until it is released and re-pressed.
  - resetRound has priority over every FSM transition in the same cycle.
- At most one of L/U/D/R is 1 in any cycle, and never for two consecutive cycles from one press when HOLD_REPEAT=0.
- Asserting reset mid-pulse or mid-hold forces all outputs to 0 immediately (asynchronous), with no pulse on release of reset.
- A key already held when reset deasserts is debounced from the released state and produces exactly one normal press pulse.

Decomposition:
- Shared package frog_pkg holds:
  - direction index constants DIR_L=3, DIR_U=2, DIR_D=1, DIR_R=0
  - the move FSM enum {IDLE, HOLD, BLOCK}
- Sub-module key_debounce (parameter DEBOUNCE_CYCLES) contains the synchronizer, the counter and the accepted level for one key. It is instantiated 4x.
- The FSM, the repeat counter and the output registers live in frog_move_encoder.

Test Plan:
- Run with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
- Reset and idle: reset=0 for 3 cycles, keyRaw=4'b1111 -> all outputs 0. Release reset and idle 30 cycles -> no pulse, no conflict.
- Single press: keyRaw[3]=0 for 12 cycles, then 1 -> L=1 for exactly one cycle, following edge 7. U/D/R stay 0 and the release produces nothing.
- Bounce rejection: keyRaw[2] toggles every 2 cycles for 12 cycles -> no U. Then held low 8 cycles -> exactly one U pulse.
- Conflict: keyRaw[3] and keyRaw[0] go low the same cycle -> conflict=1 for one cycle, L=R=0 throughout.
  - Release both, then press keyRaw[1] -> exactly one D pulse.
- Repeat: HOLD_REPEAT=1, hold keyRaw[0] low for 40 cycles -> R pulses at t0, t0+8, t0+16, t0+24, t0+32.
  - Same stimulus with HOLD_REPEAT=0 -> only the t0 pulse.
- Round and reset: hold keyRaw[2] low, then assert resetRound for 1 cycle after the first U pulse -> no further U while held. Release and re-press -> one U.
  - Drop reset during a hold -> outputs 0 at once, and no pulse until a fresh press.

Source files
------------

// File: rtl/frog_pkg.sv
// Shared definitions for the frog move encoder: direction indices, move FSM states,
// and small one-hot helpers.
package frog_pkg;

  localparam int unsigned DIR_L = 3;
  localparam int unsigned DIR_U = 2;
  localparam int unsigned DIR_D = 1;
  localparam int unsigned DIR_R = 0;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    BLOCK
  } move_state_e;

  function automatic logic is_one_hot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] dir_of(input logic [3:0] v);
    logic [1:0] dir;
    unique case (v)
      4'b1000: dir = 2'(DIR_L);
      4'b0100: dir = 2'(DIR_U);
      4'b0010: dir = 2'(DIR_D);
      default: dir = 2'(DIR_R);
    endcase
    return dir;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchronizer plus a stability counter that accepts a level
// change only after DEBOUNCE_CYCLES consecutive disagreeing samples.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_raw_i,
  output logic held_o
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // Reset to the released level so a key held through reset is seen as a fresh press.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign held_o = ~level_q;

endmodule

// File: rtl/frog_move_encoder.sv
// Turns four raw active-low buttons into registered, mutually exclusive one-cycle
// move pulses L/U/D/R, rejecting multi-key presses with a conflict pulse.
module frog_move_encoder
  import frog_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned HOLD_REPEAT     = 0,
  parameter int unsigned REPEAT_CYCLES   = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       resetRound,
  input  logic [3:0] keyRaw,
  output logic       L,
  output logic       U,
  output logic       D,
  output logic       R,
  output logic       conflict
);

  localparam int unsigned RepW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

  logic [3:0]      held;
  move_state_e     state_q, state_d;
  logic [1:0]      dir_q, dir_d;
  logic [RepW-1:0] rep_q, rep_d;
  logic [3:0]      move_q, move_d;
  logic            conflict_q, conflict_d;
  logic [3:0]      dir_onehot;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
      .clk_i    (clk),
      .rst_ni   (reset),
      .key_raw_i(keyRaw[i]),
      .held_o   (held[i])
    );
  end

  assign dir_onehot = 4'd1 << dir_q;

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    rep_d      = rep_q;
    move_d     = 4'd0;
    conflict_d = 1'b0;
    if (resetRound) begin
      // Round restart parks in BLOCK so a key held across it must be released first.
      state_d = BLOCK;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (held != 4'd0) begin
            if (is_one_hot(held)) begin
              dir_d   = dir_of(held);
              move_d  = held;
              rep_d   = '0;
              state_d = HOLD;
            end else begin
              conflict_d = 1'b1;
              state_d    = BLOCK;
            end
          end
        end
        HOLD: begin
          if (held == 4'd0) begin
            state_d = IDLE;
          end else if (held != dir_onehot) begin
            conflict_d = 1'b1;
            state_d    = BLOCK;
          end else if (HOLD_REPEAT != 0) begin
            if (rep_q == RepW'(REPEAT_CYCLES - 1)) begin
              rep_d  = '0;
              move_d = dir_onehot;
            end else begin
              rep_d = rep_q + RepW'(1);
            end
          end
        end
        BLOCK: begin
          if (held == 4'd0) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      dir_q      <= 2'd0;
      rep_q      <= '0;
      move_q     <= 4'd0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      rep_q      <= rep_d;
      move_q     <= move_d;
      conflict_q <= conflict_d;
    end
  end

  assign L        = move_q[DIR_L];
  assign U        = move_q[DIR_U];
  assign D        = move_q[DIR_D];
  assign R        = move_q[DIR_R];
  assign conflict = conflict_q;

endmodule

// File: tb/tb_frog_move_encoder.sv
// Bench for frog_move_encoder: one instance without and one with auto-repeat, both
// driven identically and scored against a behavioural model of the button rules.
module tb_frog_move_encoder;

  localparam int DB = 4;
  localparam int RC = 8;
  localparam int M_IDLE = 0, M_HOLD = 1, M_BLOCK = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       round = 1'b0;
  logic [3:0] key = 4'hF;

  logic l0, u0, d0, r0, c0, l1, u1, d1, r1, c1;
  logic [4:0] vec0, vec1;
  assign vec0 = {c0, l0, u0, d0, r0};
  assign vec1 = {c1, l1, u1, d1, r1};

  frog_move_encoder #(
    .DEBOUNCE_CYCLES(DB), .HOLD_REPEAT(0), .REPEAT_CYCLES(RC)
  ) dut0 (
    .clk(clk), .reset(rst_n), .resetRound(round), .keyRaw(key),
    .L(l0), .U(u0), .D(d0), .R(r0), .conflict(c0)
  );

  frog_move_encoder #(
    .DEBOUNCE_CYCLES(DB), .HOLD_REPEAT(1), .REPEAT_CYCLES(RC)
  ) dut1 (
    .clk(clk), .reset(rst_n), .resetRound(round), .keyRaw(key),
    .L(l1), .U(u1), .D(d1), .R(r1), .conflict(c1)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         e;
    logic [4:0] v;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int pcnt[2][5];
  int base[2][5];
  int last_edge[2][5];

  // Model state: raw-level view of each key (1 = released)
  logic [3:0] m_s1[2], m_s2[2], m_lvl[2];
  int         m_run[2][4];
  int         m_mode[2];
  logic [3:0] m_dir[2];
  int         m_since[2];

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, want, edge_n);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int b = 0; b < 5; b++) begin
        pcnt[k][b] = 0;
        last_edge[k][b] = -1;
      end
    forever begin
      @(posedge clk);
      edge_n++;
      for (int k = 0; k < 2; k++) begin
        if (!rst_n) begin
          m_s1[k] = 4'hF; m_s2[k] = 4'hF; m_lvl[k] = 4'hF;
          for (int i = 0; i < 4; i++) m_run[k][i] = 0;
          m_mode[k] = M_IDLE; m_dir[k] = 4'd0; m_since[k] = 0;
        end else begin
          logic [3:0] h;
          logic [4:0] v;
          exp_t ex;
          h = ~m_lvl[k];
          v = 5'd0;
          if (round) begin
            m_mode[k] = M_BLOCK;
          end else if (m_mode[k] == M_IDLE) begin
            if (h != 0) begin
              if ($countones(h) == 1) begin
                v[3:0] = h; m_dir[k] = h; m_since[k] = 0; m_mode[k] = M_HOLD;
              end else begin
                v[4] = 1'b1; m_mode[k] = M_BLOCK;
              end
            end
          end else if (m_mode[k] == M_HOLD) begin
            if (h == 0) m_mode[k] = M_IDLE;
            else if (h != m_dir[k]) begin
              v[4] = 1'b1; m_mode[k] = M_BLOCK;
            end else if (k == 1) begin
              m_since[k]++;
              if (m_since[k] == RC) begin
                v[3:0] = m_dir[k]; m_since[k] = 0;
              end
            end
          end else begin
            if (h == 0) m_mode[k] = M_IDLE;
          end
          if (v != 0) begin
            ex.e = edge_n; ex.v = v;
            if (k == 0) q0.push_back(ex); else q1.push_back(ex);
          end
          // A level is accepted after DB consecutive disagreeing synchronized samples
          for (int i = 0; i < 4; i++) begin
            if (m_s2[k][i] != m_lvl[k][i]) begin
              m_run[k][i]++;
              if (m_run[k][i] == DB) begin
                m_lvl[k][i] = m_s2[k][i];
                m_run[k][i] = 0;
              end
            end else begin
              m_run[k][i] = 0;
            end
          end
          m_s2[k] = m_s1[k];
          m_s1[k] = key;
        end
      end
    end
  end

  task automatic mon(input int k, input logic [4:0] got);
    logic [4:0] want;
    exp_t ex;
    want = 5'd0;
    if (k == 0) begin
      if (q0.size() > 0 && q0[0].e <= edge_n) begin
        ex = q0.pop_front();
        if (ex.e == edge_n) want = ex.v;
        else chk("stale_expect0", ex.e, edge_n);
      end
    end else begin
      if (q1.size() > 0 && q1[0].e <= edge_n) begin
        ex = q1.pop_front();
        if (ex.e == edge_n) want = ex.v;
        else chk("stale_expect1", ex.e, edge_n);
      end
    end
    if (got != 0 || want != 0) chk($sformatf("outputs_dut%0d", k), int'(got), int'(want));
    for (int b = 0; b < 5; b++)
      if (got[b]) begin
        pcnt[k][b]++;
        last_edge[k][b] = edge_n;
      end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      mon(0, vec0);
      mon(1, vec1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    for (int k = 0; k < 2; k++)
      for (int b = 0; b < 5; b++) base[k][b] = pcnt[k][b];
  endtask

  function automatic int delta(input int k, input int b);
    return pcnt[k][b] - base[k][b];
  endfunction

  function automatic int delta_all(input int k);
    int s;
    s = 0;
    for (int b = 0; b < 5; b++) s += pcnt[k][b] - base[k][b];
    return s;
  endfunction

  initial begin
    int e;
    int t;
    // Reset and idle
    tick(3);
    chk("reset_out0", int'(vec0), 0);
    chk("reset_out1", int'(vec1), 0);
    rst_n = 1'b1;
    snap();
    tick(30);
    chk("idle_pulses0", delta_all(0), 0);
    chk("idle_pulses1", delta_all(1), 0);

    // Single L press: pulse follows edge 7 counting the sampling edge as 1
    snap();
    e = edge_n + 1;
    key = 4'b0111;
    tick(12);
    key = 4'hF;
    tick(14);
    chk("single_L_count", delta(0, 3), 1);
    chk("single_L_edge", last_edge[0][3], e + 6);
    chk("single_other", delta(0, 2) + delta(0, 1) + delta(0, 0) + delta(0, 4), 0);

    // Bounce on U rejected, then a clean hold gives one U
    snap();
    for (int i = 0; i < 6; i++) begin
      key[2] = ~key[2];
      tick(2);
    end
    chk("bounce_U", delta(0, 2), 0);
    key = 4'b1011;
    tick(8);
    key = 4'hF;
    tick(14);
    chk("clean_U", delta(0, 2), 1);

    // Simultaneous L+R: conflict only, then D works
    snap();
    key = 4'b0110;
    tick(12);
    key = 4'hF;
    tick(14);
    chk("conflict_pulse", delta(0, 4), 1);
    chk("conflict_noLR", delta(0, 3) + delta(0, 0), 0);
    key = 4'b1101;
    tick(10);
    key = 4'hF;
    tick(14);
    chk("after_conflict_D", delta(0, 1), 1);

    // Auto-repeat on R: spacing of RC cycles on the repeat instance only
    snap();
    e = edge_n + 1;
    key = 4'b1110;
    tick(40);
    key = 4'hF;
    tick(14);
    chk("repeat_R_count", delta(1, 0), 5);
    chk("repeat_R_last", last_edge[1][0], e + 6 + 4 * RC);
    chk("norepeat_R_count", delta(0, 0), 1);

    // Round restart while U held: no further U until release and re-press
    snap();
    key = 4'b1011;
    t = 0;
    while (delta(0, 2) == 0 && t < 30) begin
      tick(1);
      t++;
    end
    chk("round_first_U", delta(0, 2), 1);
    round = 1'b1;
    tick(1);
    round = 1'b0;
    tick(30);
    chk("round_held_U0", delta(0, 2), 1);
    chk("round_held_U1", delta(1, 2), 1);
    key = 4'hF;
    tick(12);
    key = 4'b1011;
    tick(10);
    key = 4'hF;
    tick(14);
    chk("round_repress_U", delta(0, 2), 2);

    // Reset during a live L pulse clears outputs at once
    snap();
    key = 4'b0111;
    tick(7);
    chk("pre_reset_L", int'(l0), 1);
    rst_n = 1'b0;
    #1;
    chk("async_clear0", int'(vec0), 0);
    chk("async_clear1", int'(vec1), 0);
    key = 4'hF;
    tick(3);
    rst_n = 1'b1;
    tick(20);
    chk("post_reset_quiet", delta(0, 3), 1);
    key = 4'b1101;
    tick(2);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(12);
    key = 4'hF;
    tick(14);
    chk("held_through_reset_D", delta(0, 1), 1);

    // Randomized phase against the model
    for (int i = 0; i < 250; i++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 3) key = 4'hF;
      else if (sel < 8) key = ~(4'd1 << $urandom_range(0, 3));
      else key = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) round = 1'b1;
      tick(1);
      round = 1'b0;
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
      end
      tick(int'($urandom_range(0, 14)));
    end
    key = 4'hF;
    tick(20);
    chk("drain_q0", q0.size(), 0);
    chk("drain_q1", q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
